mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access unit: CPU load/store front end for a 64 KiB byte memory.
// Ports: clk, rst (async active-low); CPU side req/we/size/uns/addr/wdata
// in, ready/done/err/rdata out; memory side adr/d_in/mrd/mwr out, d_out in.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] adr,
  output logic [31:0] d_in,
  output logic        mrd,
  output logic        mwr,
  input  logic [31:0] d_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_uns;
  logic        r_err;
  logic [31:0] r_word;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_illegal;
  logic [31:0] w_ext;
  logic [31:0] w_din;

  assign w_accept = req && (r_state == S_IDLE);

  // Judged on the live inputs: the decision is made on the accepting edge.
  assign w_illegal = (size == 2'b11)
                   || ((size == 2'b01) && addr[0])
                   || ((size == 2'b10) && (addr[1:0] != 2'b00))
                   || (addr > 32'h0000_FFFC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_next = S_DONE;
          end else if (!we) begin
            w_next = S_LOAD;
          end else if (size == 2'b10) begin
            w_next = S_STORE;
          end else begin
            w_next = S_RMW_RD;
          end
        end
      end
      S_LOAD:   w_next = S_DONE;
      S_STORE:  w_next = S_DONE;
      S_RMW_RD: w_next = S_RMW_WR;
      S_RMW_WR: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_size  <= 2'b00;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_size  <= size;
      r_we    <= we;
      r_uns   <= uns;
      r_err   <= w_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= 32'h0;
    end else if (r_state == S_RMW_RD) begin
      r_word <= d_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'h0;
    end else if ((r_state == S_LOAD) && !r_we) begin
      r_rdata <= w_ext;
    end
  end

  always_comb begin
    w_ext = d_out;
    case (r_size)
      2'b00:   w_ext = {{24{~r_uns & d_out[7]}}, d_out[7:0]};
      2'b01:   w_ext = {{16{~r_uns & d_out[15]}}, d_out[15:0]};
      default: w_ext = d_out;
    endcase
  end

  // Sub-word merge: only the low byte/halfword of the word read back at
  // adr is replaced, so neighbouring bytes are written back untouched.
  always_comb begin
    w_din = 32'h0;
    unique case (1'b1)
      (r_state == S_STORE): w_din = r_wdata;
      (r_state == S_RMW_WR): begin
        if (r_size == 2'b00) begin
          w_din = {r_word[31:8], r_wdata[7:0]};
        end else begin
          w_din = {r_word[31:16], r_wdata[15:0]};
        end
      end
      default: w_din = 32'h0;
    endcase
  end

  assign ready = (r_state == S_IDLE);
  assign done  = (r_state == S_DONE);
  assign err   = (r_state == S_DONE) && r_err;
  assign rdata = r_rdata;
  assign adr   = (r_state == S_IDLE) ? 32'h0 : r_addr;
  assign mrd   = (r_state == S_LOAD) || (r_state == S_RMW_RD);
  assign mwr   = (r_state == S_STORE) || (r_state == S_RMW_WR);
  assign d_in  = w_din;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte memory model, vector table of accesses,
// plus hand sequences for reset-during-RMW and held-request cases.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] adr;
  logic [31:0] d_in;
  logic        mrd;
  logic        mwr;
  logic [31:0] d_out;

  int checks;
  int errors;

  logic [7:0]  mem [0:65535];
  logic        pl_we;
  logic [15:0] pl_a;
  logic [7:0]  pl_d;
  logic [15:0] ma;

  mem_access_unit dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .size  (size),
    .uns   (uns),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .done  (done),
    .err   (err),
    .rdata (rdata),
    .adr   (adr),
    .d_in  (d_in),
    .mrd   (mrd),
    .mwr   (mwr),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ma = adr[15:0];
    d_out = 32'h0;
    if (mrd) begin
      d_out = {mem[ma + 16'd3], mem[ma + 16'd2],
               mem[ma + 16'd1], mem[ma]};
    end
  end

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_a] <= pl_d;
    end else if (mwr) begin
      mem[ma]          <= d_in[7:0];
      mem[ma + 16'd1]  <= d_in[15:8];
      mem[ma + 16'd2]  <= d_in[23:16];
      mem[ma + 16'd3]  <= d_in[31:24];
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_din;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pl(input logic [15:0] a, input logic [7:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic pw(input logic [15:0] a, input logic [31:0] w);
    pl(a, w[7:0]);
    pl(a + 16'd1, w[15:8]);
    pl(a + 16'd2, w[23:16]);
    pl(a + 16'd3, w[31:24]);
  endtask

  task automatic run(input vec_t v, input int idx);
    int lat;
    int nrd;
    int nwr;
    logic [31:0] din_seen;
    bit got;
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({nm, "_ready"}, {31'h0, ready}, 32'h1);
    req   = 1'b1;
    we    = v.we;
    size  = v.size;
    uns   = v.uns;
    addr  = v.addr;
    wdata = v.wdata;
    @(posedge clk);
    #1;
    req   = 1'b0;
    we    = ~v.we;
    size  = ~v.size;
    uns   = ~v.uns;
    addr  = 32'hDEAD_BEE0;
    wdata = 32'h5A5A_5A5A;
    lat = 0;
    nrd = 0;
    nwr = 0;
    din_seen = 32'h0;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lat++;
      if (mrd) nrd++;
      if (mwr) begin
        nwr++;
        din_seen = d_in;
      end
      chk({nm, "_mrd_mwr_excl"}, {31'h0, mrd & mwr}, 32'h0);
      chk({nm, "_adr"}, adr, v.addr);
      if (!mwr) chk({nm, "_din_zero"}, d_in, 32'h0);
      if (!done) chk({nm, "_err_nodone"}, {31'h0, err}, 32'h0);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done", nm);
    end else begin
      chk({nm, "_lat"}, lat, v.exp_lat);
      chk({nm, "_err"}, {31'h0, err}, {31'h0, v.exp_err});
      chk({nm, "_rdy_in_done"}, {31'h0, ready}, 32'h0);
      chk({nm, "_rdata"}, rdata, v.exp_rdata);
      chk({nm, "_nrd"}, nrd, v.exp_rd);
      chk({nm, "_nwr"}, nwr, v.exp_wr);
      if (v.exp_wr != 0) chk({nm, "_din"}, din_seen, v.exp_din);
      @(negedge clk);
      chk({nm, "_done_1cyc"}, {31'h0, done}, 32'h0);
      chk({nm, "_ready_after"}, {31'h0, ready}, 32'h1);
      chk({nm, "_rdata_hold"}, rdata, v.exp_rdata);
    end
  endtask

  initial begin
    vec_t v;
    int lat;
    int nwr;
    int done_at;
    checks = 0;
    errors = 0;
    rst   = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    size  = 2'b00;
    uns   = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    pl_we = 1'b0;
    pl_a  = 16'h0;
    pl_d  = 8'h0;

    //         we   size   uns  addr          wdata         err   rdata         lat rd wr din
    tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 32'h807F_FE01, 2, 1, 0, 32'h0};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 1, 0, 32'h0};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 1'b0, 32'h0000_0080, 2, 1, 0, 32'h0};
    tbl[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 1'b0, 32'hFFFF_807F, 2, 1, 0, 32'h0};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 1'b0, 32'h0000_807F, 2, 1, 0, 32'h0};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0200, 32'h1234_56AB, 1'b0, 32'h0000_807F, 3, 1, 1, 32'h1122_33AB};
    tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 32'h1122_33AB, 2, 1, 0, 32'h0};
    tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0201, 32'hFFFF, 1'b1, 32'h1122_33AB, 1, 0, 0, 32'h0};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0202, 32'h0, 1'b1, 32'h1122_33AB, 1, 0, 0, 32'h0};
    tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_FFFD, 32'h0, 1'b1, 32'h1122_33AB, 1, 0, 0, 32'h0};
    tbl[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 32'h1122_33AB, 1, 0, 0, 32'h0};
    tbl[11] = '{1'b1, 2'b10, 1'b0, 32'h0000_0204, 32'hCAFE_BABE, 1'b0, 32'h1122_33AB, 2, 0, 1, 32'hCAFE_BABE};
    tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_0204, 32'h0, 1'b0, 32'hCAFE_BABE, 2, 1, 0, 32'h0};
    tbl[13] = '{1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'h1234_BEEF, 1'b0, 32'hCAFE_BABE, 3, 1, 1, 32'h0000_BEEF};
    tbl[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0204, 32'h0, 1'b0, 32'hBEEF_BABE, 2, 1, 0, 32'h0};
    tbl[15] = '{1'b0, 2'b00, 1'b0, 32'h0000_FFFC, 32'h0, 1'b0, 32'hFFFF_FF90, 2, 1, 0, 32'h0};
    tbl[16] = '{1'b0, 2'b00, 1'b1, 32'h0000_FFFD, 32'h0, 1'b1, 32'hFFFF_FF90, 1, 0, 0, 32'h0};

    #2;
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_mrd", {31'h0, mrd}, 32'h0);
    chk("rst_mwr", {31'h0, mwr}, 32'h0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_din", d_in, 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    @(negedge clk);
    pw(16'h0100, 32'h807F_FE01);
    pw(16'h0104, 32'h0000_0000);
    pw(16'h0200, 32'h1122_3344);
    pw(16'h0204, 32'h0000_0000);
    pw(16'h0208, 32'h0000_0000);
    pw(16'h0300, 32'h5566_7788);
    pw(16'hFFFC, 32'h0000_0090);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run(tbl[i], i);
    end

    // Reset while the RMW read is in flight.
    @(negedge clk);
    req   = 1'b1;
    we    = 1'b1;
    size  = 2'b01;
    uns   = 1'b0;
    addr  = 32'h0000_0300;
    wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("rmwrst_in_rd", {31'h0, mrd}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("rmwrst_ready", {31'h0, ready}, 32'h1);
    chk("rmwrst_done", {31'h0, done}, 32'h0);
    chk("rmwrst_err", {31'h0, err}, 32'h0);
    chk("rmwrst_mrd", {31'h0, mrd}, 32'h0);
    chk("rmwrst_mwr", {31'h0, mwr}, 32'h0);
    chk("rmwrst_adr", adr, 32'h0);
    chk("rmwrst_din", d_in, 32'h0);
    chk("rmwrst_rdata", rdata, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rmwrst_no_mwr", {31'h0, mwr}, 32'h0);
      chk("rmwrst_no_done", {31'h0, done}, 32'h0);
    end
    chk("rmwrst_mem", {mem[16'h0303], mem[16'h0302],
                       mem[16'h0301], mem[16'h0300]}, 32'h5566_7788);
    rst = 1'b1;
    v = '{1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 1'b0, 32'h5566_7788, 2, 1, 0, 32'h0};
    run(v, 100);

    // req held high across a word store: one store, then re-acceptance.
    @(negedge clk);
    req   = 1'b1;
    we    = 1'b1;
    size  = 2'b10;
    uns   = 1'b0;
    addr  = 32'h0000_0208;
    wdata = 32'h0102_0304;
    @(posedge clk);
    lat = 0;
    nwr = 0;
    done_at = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      lat++;
      if (mwr) nwr++;
      if (done && done_at == 0) done_at = lat;
    end
    chk("busy_done_at", done_at, 2);
    chk("busy_nwr", nwr, 1);
    chk("busy_ready_n3", {31'h0, ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("busy_reaccept", {31'h0, ready}, 32'h0);
    req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ready) break;
    end
    chk("busy_drain", {31'h0, ready}, 32'h1);
    chk("busy_mem", {mem[16'h020B], mem[16'h020A],
                     mem[16'h0209], mem[16'h0208]}, 32'h0102_0304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
